// File: rtl/mm_bridge.sv
// Main-memory bridge: turns 256b line read/write commands from the L1 cache
// into four in-order 64b beats on a pipelined memory bus and reassembles fills.
module mm_bridge #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          mm_a,
    input  logic                 mm_read_d,
    input  logic                 mm_write_d,
    input  logic [LINE_BITS-1:0] mm_writedata,
    output logic [LINE_BITS-1:0] mm_readdata,
    output logic                 mm_readdata_valid,
    output logic                 mm_ready,
    output logic [31:0]          bus_a,
    output logic                 bus_read,
    output logic                 bus_write,
    output logic [BEAT_BITS-1:0] bus_wd,
    input  logic                 bus_wait,
    input  logic [BEAT_BITS-1:0] bus_rd,
    input  logic                 bus_rd_valid
);

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    state_t               state;
    logic [2:0]           ic;
    logic [1:0]           rc;
    logic [26:0]          line_a;
    logic [LINE_BITS-1:0] wline;
    logic [2:0]           ic_inc;
    logic                 issue_ok;
    logic                 unused_ok;

    always_comb begin
        ic_inc    = ic + 3'd1;
        issue_ok  = (bus_read | bus_write) & ~bus_wait;
        unused_ok = &{1'b0, mm_a[4:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            ic                <= '0;
            rc                <= '0;
            line_a            <= '0;
            wline             <= '0;
            mm_readdata       <= '0;
            mm_readdata_valid <= 1'b0;
            mm_ready          <= 1'b0;
            bus_a             <= '0;
            bus_read          <= 1'b0;
            bus_write         <= 1'b0;
            bus_wd            <= '0;
        end else begin
            mm_readdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    mm_ready <= 1'b1;
                    ic       <= '0;
                    rc       <= '0;
                    if (mm_ready && (mm_read_d || mm_write_d)) begin
                        mm_ready <= 1'b0;
                        line_a   <= mm_a[31:5];
                        bus_a    <= {mm_a[31:5], 5'b00000};
                        // A simultaneous read is dropped; the cache re-presents it.
                        if (mm_write_d) begin
                            wline     <= mm_writedata;
                            bus_wd    <= mm_writedata[63:0];
                            bus_write <= 1'b1;
                            state     <= WR;
                        end else begin
                            bus_read <= 1'b1;
                            state    <= RD;
                        end
                    end
                end
                WR: begin
                    if (issue_ok) begin
                        ic <= ic_inc;
                        if (ic == 3'd3) begin
                            bus_write <= 1'b0;
                            mm_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            bus_a  <= {line_a, ic_inc[1:0], 3'b000};
                            bus_wd <= wline[{ic_inc[1:0], 6'b000000} +: 64];
                        end
                    end
                end
                RD: begin
                    if (issue_ok) begin
                        ic <= ic_inc;
                        if (ic == 3'd3) bus_read <= 1'b0;
                        else            bus_a    <= {line_a, ic_inc[1:0], 3'b000};
                    end
                    // Returns may coincide with issue acceptance; they only need rc.
                    if (bus_rd_valid) begin
                        mm_readdata[{rc, 6'b000000} +: 64] <= bus_rd;
                        rc <= rc + 2'd1;
                        if (rc == 2'd3) begin
                            mm_readdata_valid <= 1'b1;
                            state             <= RESP;
                        end
                    end
                end
                RESP: begin
                    mm_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
